// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter for up to 32 requesters: one-hot grant plus binary index,
// held until the owner drops its request, the enable falls, or the hold limit expires.
module rr_grant_ctrl #(
    parameter int N        = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [4:0]   gnt_id,
    output logic         gnt_valid,
    output logic         timeout,
    output logic         busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [4:0]   LAST_RST = 5'(N - 1);
    localparam logic [7:0]   HOLD_LIM = 8'(MAX_HOLD - 1);
    localparam logic [N-1:0] GNT_ONE  = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q;
    logic [N-1:0] gnt_q;
    logic [4:0]   gnt_id_q;
    logic         gnt_valid_q;
    logic         timeout_q;
    logic [4:0]   last_id_q;
    logic [7:0]   hold_cnt_q;

    // Winner search: the lowest set bit above last_id wins; otherwise wrap
    // around and take the lowest set bit at or below last_id.
    logic       hi_found_d;
    logic       lo_found_d;
    logic [4:0] hi_id_d;
    logic [4:0] lo_id_d;
    logic       win_found_d;
    logic [4:0] win_id_d;
    logic       owner_req_d;

    always_comb begin
        hi_found_d = 1'b0;
        lo_found_d = 1'b0;
        hi_id_d    = '0;
        lo_id_d    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (5'(i) > last_id_q) begin
                    hi_found_d = 1'b1;
                    hi_id_d    = 5'(i);
                end else begin
                    lo_found_d = 1'b1;
                    lo_id_d    = 5'(i);
                end
            end
        end
        win_found_d = hi_found_d | lo_found_d;
        win_id_d    = hi_found_d ? hi_id_d : lo_id_d;
    end

    // The grant is one-hot, so masking req with it picks out the owner's bit.
    assign owner_req_d = |(req & gnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            last_id_q   <= LAST_RST;
            hold_cnt_q  <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (en && win_found_d) begin
                        state_q     <= S_GRANT;
                        gnt_q       <= GNT_ONE << win_id_d;
                        gnt_id_q    <= win_id_d;
                        gnt_valid_q <= 1'b1;
                        last_id_q   <= win_id_d;
                        hold_cnt_q  <= '0;
                    end
                end
                S_GRANT: begin
                    if (!en || !owner_req_d) begin
                        state_q     <= S_IDLE;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                    end else if (hold_cnt_q == HOLD_LIM) begin
                        state_q     <= S_IDLE;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;
    assign busy      = (state_q == S_GRANT);

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (N = 32, MAX_HOLD = 4): vector table plus
// hand-written reset, mid-grant reset and full round-robin sequences.
module tb_rr_grant_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] req;
    logic [31:0] gnt;
    logic [4:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;
    logic        busy;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [31:0] req;
        logic [31:0] gnt;
        logic [4:0]  id;
        logic        valid;
        logic        to;
    } vec_t;

    vec_t tbl[$];

    rr_grant_ctrl #(.N(32), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic drive(input logic r, input logic e, input logic [31:0] q);
        @(negedge clk);
        rst_n = r;
        en    = e;
        req   = q;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic r, input logic e, input logic [31:0] q,
                           input logic [31:0] g, input logic [4:0] id,
                           input logic v, input logic t);
        vec_t x;
        x.rst_n = r; x.en = e; x.req = q; x.gnt = g; x.id = id; x.valid = v; x.to = t;
        tbl.push_back(x);
    endtask

    // Scoreboard comparison
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] g, input logic [4:0] id,
                             input logic v, input logic t);
        check({tag, " gnt"},       gnt,              g);
        check({tag, " gnt_id"},    32'(gnt_id),      32'(id));
        check({tag, " gnt_valid"}, 32'(gnt_valid),   32'(v));
        check({tag, " busy"},      32'(busy),        32'(v));
        check({tag, " timeout"},   32'(timeout),     32'(t));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        req      = $urandom;

        // Reset release with req=0x8, then a MAX_HOLD=4 timeout on requester 5
        add_vec(1, 1, 32'h0000_0008, 32'h0000_0008, 5'd3, 1, 0);
        add_vec(1, 1, 32'h0000_0000, 32'h0000_0000, 5'd3, 0, 0);
        add_vec(1, 1, 32'h0000_0000, 32'h0000_0000, 5'd3, 0, 0);
        add_vec(1, 1, 32'h0000_0020, 32'h0000_0020, 5'd5, 1, 0);
        add_vec(1, 1, 32'h0000_0020, 32'h0000_0020, 5'd5, 1, 0);
        add_vec(1, 1, 32'h0000_0020, 32'h0000_0020, 5'd5, 1, 0);
        add_vec(1, 1, 32'h0000_0020, 32'h0000_0020, 5'd5, 1, 0);
        add_vec(1, 1, 32'h0000_0020, 32'h0000_0000, 5'd5, 0, 1);
        add_vec(1, 1, 32'h0000_0020, 32'h0000_0020, 5'd5, 1, 0);
        add_vec(1, 1, 32'h0000_0000, 32'h0000_0000, 5'd5, 0, 0);
        // Enable dropped mid-grant, blocked while low, resumes from last_id=7
        add_vec(1, 1, 32'h0000_0080, 32'h0000_0080, 5'd7, 1, 0);
        add_vec(1, 0, 32'h0000_0080, 32'h0000_0000, 5'd7, 0, 0);
        add_vec(1, 0, 32'h0000_00FF, 32'h0000_0000, 5'd7, 0, 0);
        add_vec(1, 0, 32'h0000_00FF, 32'h0000_0000, 5'd7, 0, 0);
        add_vec(1, 1, 32'h0000_0108, 32'h0000_0100, 5'd8, 1, 0);
        add_vec(1, 1, 32'h0000_0000, 32'h0000_0000, 5'd8, 0, 0);
        // Wrap and fairness between 30 and 0
        add_vec(1, 1, 32'h4000_0000, 32'h4000_0000, 5'd30, 1, 0);
        add_vec(1, 1, 32'h0000_0000, 32'h0000_0000, 5'd30, 0, 0);
        add_vec(1, 1, 32'h4000_0001, 32'h0000_0001, 5'd0, 1, 0);
        add_vec(1, 1, 32'h4000_0000, 32'h0000_0000, 5'd0, 0, 0);
        add_vec(1, 1, 32'h4000_0000, 32'h4000_0000, 5'd30, 1, 0);
        add_vec(1, 1, 32'h0000_0000, 32'h0000_0000, 5'd30, 0, 0);
        // last_id=31 wraps to 0
        add_vec(1, 1, 32'h8000_0000, 32'h8000_0000, 5'd31, 1, 0);
        add_vec(1, 1, 32'h0000_0000, 32'h0000_0000, 5'd31, 0, 0);
        add_vec(1, 1, 32'h8000_0001, 32'h0000_0001, 5'd0, 1, 0);
        add_vec(1, 1, 32'h0000_0000, 32'h0000_0000, 5'd0, 0, 0);
        // Pending requester waits out the current grant plus one idle cycle
        add_vec(1, 1, 32'h0000_0006, 32'h0000_0002, 5'd1, 1, 0);
        add_vec(1, 1, 32'h0000_0004, 32'h0000_0000, 5'd1, 0, 0);
        add_vec(1, 1, 32'h0000_0004, 32'h0000_0004, 5'd2, 1, 0);
        add_vec(1, 1, 32'h0000_0000, 32'h0000_0000, 5'd2, 0, 0);

        // Reset state with random requests
        step();
        step();
        check_all("reset", 32'h0, 5'd0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].en, tbl[i].req);
            step();
            check_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].valid, tbl[i].to);
        end

        // Asynchronous reset in the middle of a grant to requester 8
        drive(1, 1, 32'h0000_0100);
        step();
        check_all("pre_rst grant", 32'h0000_0100, 5'd8, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 5'd0, 1'b0, 1'b0);
        drive(1, 1, 32'h0000_0300);
        step();
        check_all("post_rst grant", 32'h0000_0100, 5'd8, 1'b1, 1'b0);
        drive(1, 1, 32'h0);
        step();
        check_all("post_rst release", 32'h0, 5'd8, 1'b0, 1'b0);

        // Full round-robin sweep from a fresh reset: 0..31 then 0 again
        drive(0, 1, 32'h0);
        drive(1, 1, 32'hFFFF_FFFF);
        for (int g = 0; g < 33; g++) begin
            logic [4:0]  w;
            logic [31:0] bit_w;
            w     = 5'(g % 32);
            bit_w = 32'h1 << w;
            step();
            check_all($sformatf("rr%0d c1", g), bit_w, w, 1'b1, 1'b0);
            drive(1, 1, 32'hFFFF_FFFF);
            step();
            check_all($sformatf("rr%0d c2", g), bit_w, w, 1'b1, 1'b0);
            drive(1, 1, ~bit_w);
            step();
            check_all($sformatf("rr%0d gap", g), 32'h0, w, 1'b0, 1'b0);
            drive(1, 1, 32'hFFFF_FFFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
